// File: rtl/copy_path_arbiter.sv
// Two-requester round-robin arbiter with bounded bursts, feeding one registered
// valid/ready output stage on the shared 16-bit copy datapath.
module copy_path_arbiter #(
    parameter int WIDTH     = 16,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       grant,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_e;

    localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic [3:0]       beat_cnt_q, beat_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [1:0]       grant_q, grant_d;
    logic             busy_q, busy_d;

    logic             stage_free_s;
    logic             accept_s;
    logic             release_s;
    logic             own_valid_s;
    logic             other_valid_s;
    logic [WIDTH-1:0] own_data_s;

    function automatic logic [1:0] grant_of(input state_e st);
        case (st)
            OWN0:    grant_of = 2'b01;
            OWN1:    grant_of = 2'b10;
            default: grant_of = 2'b00;
        endcase
    endfunction

    // Ready goes straight back from out_ready so a draining stage accepts in the same cycle.
    assign stage_free_s = !out_valid_q || out_ready;
    assign req0_ready   = (state_q == OWN0) && stage_free_s;
    assign req1_ready   = (state_q == OWN1) && stage_free_s;
    assign accept_s     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign release_s    = (state_q != IDLE) &&
                          (!own_valid_s || (accept_s && (beat_cnt_q == LAST_BEAT)));

    // Select the owning and the waiting requester's signals for the current state.
    always_comb begin
        own_valid_s   = 1'b0;
        other_valid_s = 1'b0;
        own_data_s    = {WIDTH{1'b0}};
        case (state_q)
            OWN0: begin
                own_valid_s   = req0_valid;
                other_valid_s = req1_valid;
                own_data_s    = req0_data;
            end
            OWN1: begin
                own_valid_s   = req1_valid;
                other_valid_s = req0_valid;
                own_data_s    = req1_data;
            end
            default: begin
                own_valid_s   = 1'b0;
                other_valid_s = 1'b0;
                own_data_s    = {WIDTH{1'b0}};
            end
        endcase
    end

    // Ownership sequencing: tie-break against the last released requester.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (req0_valid && req1_valid) begin
                    state_d = last_q ? OWN0 : OWN1;
                end else if (req0_valid) begin
                    state_d = OWN0;
                end else if (req1_valid) begin
                    state_d = OWN1;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN0, OWN1: begin
                if (release_s) begin
                    last_d     = (state_q == OWN1);
                    beat_cnt_d = 4'd0;
                    if (other_valid_s) begin
                        state_d = (state_q == OWN0) ? OWN1 : OWN0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (accept_s) begin
                    beat_cnt_d = beat_cnt_q + 4'd1;
                end else begin
                    beat_cnt_d = beat_cnt_q;
                end
            end
            default: begin
                state_d    = IDLE;
                last_d     = 1'b1;
                beat_cnt_d = 4'd0;
            end
        endcase
    end

    // Output stage: load on accept, drain on consumer take, otherwise hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (accept_s) begin
            out_valid_d = 1'b1;
            out_data_d  = own_data_s;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            out_data_d  = out_data_q;
        end else begin
            out_valid_d = out_valid_q;
            out_data_d  = out_data_q;
        end
        grant_d = grant_of(state_d);
        busy_d  = (state_d != IDLE) || out_valid_d;
    end

    // State and registered outputs; reset discards any beat held in the stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            beat_cnt_q  <= 4'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= {WIDTH{1'b0}};
            grant_q     <= 2'b00;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            beat_cnt_q  <= beat_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign grant     = grant_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_copy_path_arbiter.sv
// Bench for copy_path_arbiter: two instances (MAX_BURST 4 and 1) checked every
// cycle against a behavioural ownership/queue model plus hand-computed literals.
module tb_copy_path_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        vld  [2][2];
    logic [15:0] dat  [2][2];
    logic        rdy  [2][2];
    logic        ordy [2];
    logic        ov_o [2];
    logic [15:0] od_o [2];
    logic [1:0]  gr_o [2];
    logic        bz_o [2];

    copy_path_arbiter #(.WIDTH(16), .MAX_BURST(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(vld[0][0]), .req0_data(dat[0][0]), .req0_ready(rdy[0][0]),
        .req1_valid(vld[0][1]), .req1_data(dat[0][1]), .req1_ready(rdy[0][1]),
        .out_valid(ov_o[0]), .out_data(od_o[0]), .out_ready(ordy[0]),
        .grant(gr_o[0]), .busy(bz_o[0])
    );

    copy_path_arbiter #(.WIDTH(16), .MAX_BURST(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(vld[1][0]), .req0_data(dat[1][0]), .req0_ready(rdy[1][0]),
        .req1_valid(vld[1][1]), .req1_data(dat[1][1]), .req1_ready(rdy[1][1]),
        .out_valid(ov_o[1]), .out_data(od_o[1]), .out_ready(ordy[1]),
        .grant(gr_o[1]), .busy(bz_o[1])
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Producers: each sends rem beats of base + step*idx.
    int          rem    [2][2];
    int          idx    [2][2];
    logic [15:0] base   [2][2];
    logic [15:0] step   [2][2];
    bit          fire   [2][2];
    logic        ordy_c [2];

    // Model: owner (-1 none), beats in current grant, last released, output stage.
    int          m_own  [2];
    int          m_cnt  [2];
    int          m_last [2];
    bit          m_ov   [2];
    logic [15:0] m_od   [2];
    int          mb     [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_own[k]  = -1;
            m_cnt[k]  = 0;
            m_last[k] = 1;
            m_ov[k]   = 1'b0;
            m_od[k]   = 16'h0000;
        end
    endtask

    task automatic model_step(input int k);
        bit v [2];
        bit acc;
        int o;
        v[0] = vld[k][0];
        v[1] = vld[k][1];
        o    = m_own[k];
        acc  = 1'b0;
        if (o >= 0) acc = v[o] && (!m_ov[k] || ordy[k]);
        if (acc) begin
            m_ov[k] = 1'b1;
            m_od[k] = dat[k][o];
        end else if (ordy[k]) begin
            m_ov[k] = 1'b0;
        end
        if (o < 0) begin
            if (v[0] && v[1]) m_own[k] = 1 - m_last[k];
            else if (v[0])    m_own[k] = 0;
            else if (v[1])    m_own[k] = 1;
        end else if (!v[o] || (acc && (m_cnt[k] + 1 == mb[k]))) begin
            m_last[k] = o;
            m_cnt[k]  = 0;
            m_own[k]  = v[1 - o] ? 1 - o : -1;
        end else if (acc) begin
            m_cnt[k] = m_cnt[k] + 1;
        end
    endtask

    task automatic check(input int k);
        logic [1:0] eg;
        logic       eb, er0, er1;
        eg  = (m_own[k] == 0) ? 2'b01 : (m_own[k] == 1) ? 2'b10 : 2'b00;
        eb  = (m_own[k] >= 0) || m_ov[k];
        er0 = (m_own[k] == 0) && (!m_ov[k] || ordy[k]);
        er1 = (m_own[k] == 1) && (!m_ov[k] || ordy[k]);
        n_tests++;
        if (gr_o[k] !== eg || ov_o[k] !== m_ov[k] || od_o[k] !== m_od[k] ||
            bz_o[k] !== eb || rdy[k][0] !== er0 || rdy[k][1] !== er1) begin
            n_fail++;
            $display("FAIL cycle dut%0d t=%0t: grant %b/%b valid %b/%b data %h/%h busy %b/%b rdy0 %b/%b rdy1 %b/%b (got/want)",
                     k, $time, gr_o[k], eg, ov_o[k], m_ov[k], od_o[k], m_od[k],
                     bz_o[k], eb, rdy[k][0], er0, rdy[k][1], er1);
        end
    endtask

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic prod(input int k, input int r, input int n, input logic [15:0] b, input logic [15:0] s);
        rem[k][r]  = n;
        idx[k][r]  = 0;
        base[k][r] = b;
        step[k][r] = s;
    endtask

    // One clock: model advances at the edge, checks and new drive at the falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            model_step(0);
            model_step(1);
        end
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < 2; r++)
                if (fire[k][r]) begin
                    idx[k][r] = idx[k][r] + 1;
                    rem[k][r] = rem[k][r] - 1;
                end
        @(negedge clk);
        check(0);
        check(1);
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 2; r++) begin
                vld[k][r] = (rem[k][r] > 0);
                dat[k][r] = base[k][r] + step[k][r] * 16'(idx[k][r]);
            end
            ordy[k] = ordy_c[k];
        end
        #1;
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < 2; r++)
                fire[k][r] = vld[k][r] && rdy[k][r];
    endtask

    task automatic lit_all_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            lit({tag, "_grant"}, 32'(gr_o[k]), 32'h0);
            lit({tag, "_valid"}, 32'(ov_o[k]), 32'h0);
            lit({tag, "_data"},  32'(od_o[k]), 32'h0);
            lit({tag, "_busy"},  32'(bz_o[k]), 32'h0);
            lit({tag, "_rdy0"},  32'(rdy[k][0]), 32'h0);
            lit({tag, "_rdy1"},  32'(rdy[k][1]), 32'h0);
        end
    endtask

    initial begin
        mb[0] = 4;
        mb[1] = 1;
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 2; r++) begin
                vld[k][r] = 1'b0;
                dat[k][r] = 16'h0000;
                fire[k][r] = 1'b0;
                prod(k, r, 0, 16'h0000, 16'h0000);
            end
            ordy[k]   = 1'b1;
            ordy_c[k] = 1'b1;
        end
        model_reset();
        #2;
        lit_all_zero("reset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Tie on dut4 (groups of 4) and alternation on dut1 (MAX_BURST 1).
        prod(0, 0, 8, 16'hA000, 16'h0001);
        prod(0, 1, 8, 16'hB000, 16'h0001);
        prod(1, 0, 4, 16'h1000, 16'h0001);
        prod(1, 1, 4, 16'h2000, 16'h0001);
        tick();
        for (int t = 1; t <= 12; t++) begin
            tick();
            lit("tie_grant", 32'(gr_o[0]), (t <= 4 || t >= 9) ? 32'h1 : 32'h2);
            if (t >= 2 && t <= 9)
                lit("tie_data", 32'(od_o[0]),
                    (t <= 5) ? 32'hA000 + 32'(t - 2) : 32'hB000 + 32'(t - 6));
            if (t <= 6)
                lit("mb1_grant", 32'(gr_o[1]), (t % 2 == 1) ? 32'h1 : 32'h2);
        end
        prod(0, 0, 0, 16'h0000, 16'h0000);
        prod(0, 1, 0, 16'h0000, 16'h0000);
        repeat (4) tick();

        // Single requester, three beats.
        prod(0, 0, 3, 16'h1111, 16'h1111);
        tick();
        tick();
        lit("single_grant", 32'(gr_o[0]), 32'h1);
        lit("single_v0",    32'(ov_o[0]), 32'h0);
        tick();
        lit("single_v1",    32'(ov_o[0]), 32'h1);
        lit("single_d1",    32'(od_o[0]), 32'h1111);
        tick();
        lit("single_d2",    32'(od_o[0]), 32'h2222);
        tick();
        lit("single_d3",    32'(od_o[0]), 32'h3333);
        tick();
        lit("single_idle",  32'(gr_o[0]), 32'h0);
        lit("single_busy",  32'(bz_o[0]), 32'h0);
        repeat (2) tick();

        // Backpressure with 16'hBEEF held for 5 cycles.
        prod(0, 1, 2, 16'hBEEF, 16'h0001);
        tick();
        tick();
        lit("bp_grant", 32'(gr_o[0]), 32'h2);
        ordy_c[0] = 1'b0;
        tick();
        lit("bp_valid", 32'(ov_o[0]), 32'h1);
        lit("bp_data",  32'(od_o[0]), 32'hBEEF);
        for (int i = 0; i < 4; i++) begin
            tick();
            lit("bp_hold", 32'(od_o[0]), 32'hBEEF);
            lit("bp_rdy",  32'(rdy[0][1]), 32'h0);
        end
        ordy_c[0] = 1'b1;
        tick();
        lit("bp_hold_last", 32'(od_o[0]), 32'hBEEF);
        lit("bp_rdy_back",  32'(rdy[0][1]), 32'h1);
        tick();
        lit("bp_next", 32'(od_o[0]), 32'hBEF0);
        repeat (3) tick();

        // Early release: req1 drops after 2 beats while req0 waits.
        prod(0, 1, 2, 16'hC000, 16'h0001);
        tick();
        tick();
        prod(0, 0, 3, 16'hD000, 16'h0001);
        tick();
        tick();
        lit("early_own1", 32'(gr_o[0]), 32'h2);
        tick();
        lit("early_own0", 32'(gr_o[0]), 32'h1);
        repeat (6) tick();

        // Reset in the middle of an OWN1 burst with a beat in the stage.
        prod(0, 1, 6, 16'hE000, 16'h0001);
        tick();
        tick();
        tick();
        lit("pre_rst_valid", 32'(ov_o[0]), 32'h1);
        lit("pre_rst_grant", 32'(gr_o[0]), 32'h2);
        #2;
        rst_n = 1'b0;
        model_reset();
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < 2; r++) begin
                fire[k][r] = 1'b0;
                prod(k, r, 0, 16'h0000, 16'h0000);
            end
        #1;
        lit_all_zero("async_rst");
        tick();
        tick();
        rst_n = 1'b1;
        prod(0, 0, 3, 16'h5000, 16'h0001);
        prod(0, 1, 3, 16'h6000, 16'h0001);
        tick();
        tick();
        lit("post_rst_grant", 32'(gr_o[0]), 32'h1);
        repeat (10) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
